// File: rtl/iterator_arbiter.sv
// iterator_arbiter: round-robin sharing of one Iterator among NUM_REQ users.
// Ports: clock, reset (sync, active-high); req/rew per requester in;
// gnt, rsp_valid, rsp_data, rsp_eof, busy out; itr_read/itr_reset to the
// Iterator, itr_val/itr_eof from it.
// Define ITER_ARB_STATS_EN to add stat_reads/stat_eofs/stat_rewinds.
module iterator_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rew,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_eof,
  output logic                 busy,
  output logic                 itr_read,
  output logic                 itr_reset,
  input  logic [WORD_SIZE-1:0] itr_val,
  input  logic                 itr_eof
`ifdef ITER_ARB_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_eofs,
  output logic [31:0]          stat_rewinds
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] rr;
  logic [IW-1:0] win;
  logic          op_rew;
  logic          skip;
  logic [IW:0]   rew_pick;
  logic [IW:0]   req_pick;
  logic          take_rew;
  logic          any;
  logic [IW-1:0] pick_idx;

  // First set bit at or after start, wrapping. MSB of result = found.
  // Scanning downward lets the closest hit overwrite farther ones.
  function automatic logic [IW:0] first_from(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      start
  );
    logic [IW:0] r;
    logic [IW:0] s;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, start} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
      if (v[s[IW-1:0]]) r = {1'b1, s[IW-1:0]};
    end
    return r;
  endfunction

  assign rew_pick = first_from(rew, rr);
  assign req_pick = first_from(req, rr);
  assign take_rew = rew_pick[IW];
  assign any      = rew_pick[IW] | req_pick[IW];
  assign pick_idx = take_rew ? rew_pick[IW-1:0]
                             : req_pick[IW-1:0];
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt       <= '0;
      win       <= '0;
      rr        <= '0;
      op_rew    <= 1'b0;
      skip      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_eof   <= 1'b0;
      itr_read  <= 1'b0;
      itr_reset <= 1'b0;
    end else begin
      itr_read  <= 1'b0;
      itr_reset <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            win       <= pick_idx;
            gnt       <= NUM_REQ'(1) << pick_idx;
            op_rew    <= take_rew;
            // A read at eof is answered without touching the Iterator.
            skip      <= !take_rew && itr_eof;
            itr_read  <= !take_rew && !itr_eof;
            itr_reset <= take_rew;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= (!op_rew && !skip) ? itr_val : '0;
          rsp_eof   <= itr_eof;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          gnt       <= '0;
          rr        <= (win == IW'(NUM_REQ - 1)) ? '0
                                                 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ITER_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads   <= '0;
      stat_eofs    <= '0;
      stat_rewinds <= '0;
    end else if (state == CAPTURE) begin
      if (!op_rew && !skip && stat_reads != '1)
        stat_reads <= stat_reads + 32'd1;
      if (itr_eof && stat_eofs != '1)
        stat_eofs <= stat_eofs + 32'd1;
      if (op_rew && stat_rewinds != '1)
        stat_rewinds <= stat_rewinds + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iterator_arbiter.sv
// tb_iterator_arbiter: randomized and directed bench for iterator_arbiter
// with a file-backed Iterator model and a transaction-level reference.
module tb_iterator_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] rew;
  logic [N-1:0] gnt;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_eof;
  logic         busy;
  logic         itr_read;
  logic         itr_reset;
  logic [W-1:0] itr_val;
  logic         itr_eof;
`ifdef ITER_ARB_STATS_EN
  logic [31:0]  stat_reads;
  logic [31:0]  stat_eofs;
  logic [31:0]  stat_rewinds;
`endif

  always #5 clock = ~clock;

  iterator_arbiter #(.NUM_REQ(N), .WORD_SIZE(W)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .rew(rew),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_eof(rsp_eof),
    .busy(busy),
    .itr_read(itr_read),
    .itr_reset(itr_reset),
    .itr_val(itr_val),
    .itr_eof(itr_eof)
`ifdef ITER_ARB_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_eofs(stat_eofs),
    .stat_rewinds(stat_rewinds)
`endif
  );

  // File-backed Iterator: a read presents the next word, eof after last.
  logic [7:0] fmem [64];
  int         flen = 0;
  int         fp;

  always @(posedge clock) begin
    if (reset || itr_reset) begin
      fp      <= 0;
      itr_val <= '0;
      itr_eof <= (flen == 0);
    end else if (itr_read) begin
      itr_val <= (fp < flen) ? fmem[fp] : 8'h00;
      itr_eof <= (fp + 1 >= flen);
      fp      <= fp + 1;
    end
  end

  int vecs = 0;
  int errs = 0;

  // Transaction-level reference state.
  int           n;
  int           t0;
  bit           act;
  int           m_win;
  bit           m_rew;
  bit           m_skip;
  logic [7:0]   m_data;
  bit           m_eof;
  int           m_rr;
  int           m_ptr;
  bit           m_feof;
  int           tal_reads;
  int           tal_eofs;
  int           tal_rews;
  logic [N-1:0] pend_req;
  logic [N-1:0] pend_rew;
  logic [N-1:0] s_req;
  logic [N-1:0] s_rew;
  bit           s_sticky;
  bit           s_first;
  bit           s_stop;
  int           s_rate;

  logic [N-1:0] lg_gnt [$];
  logic [7:0]   lg_data [$];
  logic         lg_eof [$];

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    rew      = '0;
    pend_req = '0;
    pend_rew = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    n         = 0;
    t0        = -100;
    act       = 0;
    m_rr      = 0;
    m_ptr     = 0;
    m_feof    = (flen == 0);
    tal_reads = 0;
    tal_eofs  = 0;
    tal_rews  = 0;
    lg_gnt.delete();
    lg_data.delete();
    lg_eof.delete();
  endtask

  // Arbitration decision at an edge where the arbiter is free.
  task automatic sample();
    logic [N-1:0] v;
    int           i;
    if (act && n - t0 < 4) return;
    act = 0;
    if ((pend_req | pend_rew) == '0) return;
    m_rew = (pend_rew != '0);
    v = m_rew ? pend_rew : pend_req;
    for (int k = N - 1; k >= 0; k--) begin
      i = (m_rr + k) % N;
      if (v[i]) m_win = i;
    end
    m_rr = (m_win + 1) % N;
    act  = 1;
    t0   = n;
    if (m_rew) begin
      m_ptr  = 0;
      m_feof = (flen == 0);
      m_skip = 0;
      m_data = 8'h00;
      tal_rews++;
    end else if (m_feof) begin
      m_skip = 1;
      m_data = 8'h00;
    end else begin
      m_skip = 0;
      m_data = fmem[m_ptr];
      m_ptr++;
      m_feof = (m_ptr >= flen);
      tal_reads++;
    end
    m_eof = m_feof;
    if (m_eof) tal_eofs++;
  endtask

  // One cycle, entered and left at a negedge.
  task automatic step();
    int           d;
    bit           on;
    logic [N-1:0] eg;
    logic [4:0]   ex;
    logic [4:0]   ob;
    d  = n - t0;
    on = act && d >= 0 && d <= 2;
    eg = '0;
    if (on) eg[m_win] = 1'b1;
    ex = {on && d == 2, on && d == 0 && !m_rew && !m_skip,
          on && d == 0 && m_rew, on, 1'b0};
    ob = {rsp_valid, itr_read, itr_reset, busy, 1'b0};
    vecs++;
    if (gnt !== eg || ob !== ex) begin
      errs++;
      $display("FAIL cycle%0d ctl: gnt=%b v/rd/rs/busy=%b expected %b %b",
               n, gnt, ob[4:1], eg, ex[4:1]);
    end
    if (on && d == 2) begin
      vecs++;
      if (rsp_data !== m_data || rsp_eof !== m_eof) begin
        errs++;
        $display("FAIL cycle%0d rsp: data=%h eof=%b expected %h %b",
                 n, rsp_data, rsp_eof, m_data, m_eof);
      end
      if (m_rew) pend_rew[m_win] = 1'b0;
      else       pend_req[m_win] = 1'b0;
    end
    if (rsp_valid === 1'b1) begin
      lg_gnt.push_back(gnt);
      lg_data.push_back(rsp_data);
      lg_eof.push_back(rsp_eof);
    end
    if (!s_stop) begin
      if (s_first || s_sticky) begin
        pend_req |= s_req;
        pend_rew |= s_rew;
      end
      if (s_rate > 0) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(s_rate - 1) == 0) pend_req[i] = 1'b1;
          if ($urandom_range(3 * s_rate - 1) == 0) pend_rew[i] = 1'b1;
        end
      end
    end
    s_first = 0;
    req = pend_req;
    rew = pend_rew;
    @(posedge clock);
    n++;
    sample();
    @(negedge clock);
  endtask

  task automatic run(input int cycles, input logic [N-1:0] rq,
                     input logic [N-1:0] rw, input bit sticky,
                     input int rate);
    bit done;
    s_req    = rq;
    s_rew    = rw;
    s_sticky = sticky;
    s_rate   = rate;
    s_first  = 1;
    s_stop   = 0;
    repeat (cycles) step();
    s_stop = 1;
    done   = 0;
    for (int b = 0; b < 300 && !done; b++) begin
      if (pend_req == '0 && pend_rew == '0 && (!act || n - t0 >= 3))
        done = 1;
      else
        step();
    end
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL drain: requests still pending=%b/%b required 0",
               pend_req, pend_rew);
    end
  endtask

  task automatic test_reset();
    flen = 2;
    do_reset();
    vecs++;
    if ({gnt, rsp_valid, rsp_data, rsp_eof, busy, itr_read, itr_reset}
        !== '0) begin
      errs++;
      $display("FAIL reset: gnt=%b v=%b d=%h e=%b busy=%b rd=%b rs=%b req 0",
               gnt, rsp_valid, rsp_data, rsp_eof, busy, itr_read,
               itr_reset);
    end
  endtask

  task automatic test_single_file();
    logic [7:0] ed [3];
    logic       ee [3];
    ed = '{8'h11, 8'h22, 8'h00};
    ee = '{1'b0, 1'b1, 1'b1};
    flen    = 2;
    fmem[0] = 8'h11;
    fmem[1] = 8'h22;
    do_reset();
    run(12, 4'b0001, 4'b0000, 1, 0);
    vecs++;
    if (lg_data.size() < 3) begin
      errs++;
      $display("FAIL single count: got %0d responses required >=3",
               lg_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (lg_data[i] !== ed[i] || lg_eof[i] !== ee[i]) begin
          errs++;
          $display("FAIL single rsp%0d: %h/%b required %h/%b",
                   i, lg_data[i], lg_eof[i], ed[i], ee[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg [5];
    eg   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    flen = 8;
    for (int i = 0; i < 8; i++) fmem[i] = 8'(8'h40 + i);
    do_reset();
    run(20, 4'b1111, 4'b0000, 1, 0);
    vecs++;
    if (lg_gnt.size() < 5) begin
      errs++;
      $display("FAIL rr count: got %0d responses required >=5",
               lg_gnt.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vecs++;
        if (lg_gnt[i] !== eg[i] || lg_data[i] !== fmem[i]) begin
          errs++;
          $display("FAIL rr grant%0d: %b/%h required %b/%h",
                   i, lg_gnt[i], lg_data[i], eg[i], fmem[i]);
        end
      end
    end
  endtask

  task automatic test_rewind_priority();
    logic [N-1:0] eg [3];
    eg   = '{4'b0100, 4'b0001, 4'b0010};
    flen = 4;
    for (int i = 0; i < 4; i++) fmem[i] = 8'(8'hA0 + i);
    do_reset();
    run(4, 4'b0011, 4'b0100, 0, 0);
    vecs++;
    if (lg_gnt.size() != 3) begin
      errs++;
      $display("FAIL rew count: got %0d responses required 3",
               lg_gnt.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (lg_gnt[i] !== eg[i]) begin
          errs++;
          $display("FAIL rew order%0d: %b required %b",
                   i, lg_gnt[i], eg[i]);
        end
      end
      vecs++;
      if (lg_eof[0] !== 1'b0 || lg_data[0] !== 8'h00) begin
        errs++;
        $display("FAIL rew rsp: %h/%b required 00/0",
                 lg_data[0], lg_eof[0]);
      end
    end
  endtask

  task automatic test_reset_in_capture();
    flen    = 3;
    fmem[0] = 8'h05;
    fmem[1] = 8'h06;
    fmem[2] = 8'h07;
    do_reset();
    req = 4'b0010;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vecs++;
    if ({gnt, rsp_valid, rsp_data, rsp_eof, busy, itr_read, itr_reset}
        !== '0) begin
      errs++;
      $display("FAIL abort: gnt=%b v=%b d=%h e=%b busy=%b rd=%b rs=%b req 0",
               gnt, rsp_valid, rsp_data, rsp_eof, busy, itr_read,
               itr_reset);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      vecs++;
      if (rsp_valid !== (c == 2) || gnt !== 4'b0010) begin
        errs++;
        $display("FAIL restart c%0d: v=%b gnt=%b required %b 0010",
                 c, rsp_valid, gnt, c == 2);
      end
    end
    vecs++;
    if (rsp_data !== 8'h05 || rsp_eof !== 1'b0) begin
      errs++;
      $display("FAIL restart rsp: %h/%b required 05/0", rsp_data, rsp_eof);
    end
    req = '0;
    @(posedge clock);
    @(negedge clock);
    vecs++;
    if (rsp_valid !== 1'b0 || gnt !== '0) begin
      errs++;
      $display("FAIL restart end: v=%b gnt=%b required 0 0000",
               rsp_valid, gnt);
    end
  endtask

  task automatic test_drop_after_grant();
    logic [7:0] ev [2];
    ev      = '{8'h05, 8'h06};
    flen    = 3;
    fmem[0] = 8'h05;
    fmem[1] = 8'h06;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      req = 4'b0001;
      @(posedge clock);
      @(negedge clock);
      req = '0;
      vecs++;
      if (itr_read !== 1'b1) begin
        errs++;
        $display("FAIL drop rd%0d: %b required 1", t, itr_read);
      end
      repeat (2) begin
        @(posedge clock);
        @(negedge clock);
      end
      vecs++;
      if (rsp_valid !== 1'b1 || gnt !== 4'b0001 || rsp_data !== ev[t]) begin
        errs++;
        $display("FAIL drop rsp%0d: v=%b gnt=%b d=%h required 1 0001 %h",
                 t, rsp_valid, gnt, rsp_data, ev[t]);
      end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      flen = $urandom_range(6);
      for (int i = 0; i < flen; i++) fmem[i] = 8'($urandom_range(1, 255));
      do_reset();
      run(150, '0, '0, 0, 2 + r);
`ifdef ITER_ARB_STATS_EN
      vecs++;
      if (stat_reads !== 32'(tal_reads) || stat_eofs !== 32'(tal_eofs) ||
          stat_rewinds !== 32'(tal_rews)) begin
        errs++;
        $display("FAIL rnd stats: %0d/%0d/%0d required %0d/%0d/%0d",
                 stat_reads, stat_eofs, stat_rewinds,
                 tal_reads, tal_eofs, tal_rews);
      end
`endif
    end
  endtask

`ifdef ITER_ARB_STATS_EN
  task automatic test_stats();
    flen    = 3;
    fmem[0] = 8'h31;
    fmem[1] = 8'h32;
    fmem[2] = 8'h33;
    do_reset();
    vecs++;
    if (stat_reads !== '0 || stat_eofs !== '0 || stat_rewinds !== '0) begin
      errs++;
      $display("FAIL stats reset: %0d/%0d/%0d required 0/0/0",
               stat_reads, stat_eofs, stat_rewinds);
    end
    run(14, 4'b0001, 4'b0000, 1, 0);
    run(2, 4'b0000, 4'b0001, 0, 0);
    vecs++;
    if (stat_reads !== 32'd3 || stat_rewinds !== 32'd1 ||
        stat_eofs !== 32'(tal_eofs)) begin
      errs++;
      $display("FAIL stats: %0d/%0d/%0d required 3/%0d/1",
               stat_reads, stat_eofs, stat_rewinds, tal_eofs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_file();
    test_round_robin();
    test_rewind_priority();
    test_reset_in_capture();
    test_drop_after_grant();
    test_random();
`ifdef ITER_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
